ysyx_041514_lsu_store: RTL

- Store-side counterpart of the load sign-extension path in the LSU.
- Takes one store request (address, unaligned XLEN data, one-hot size), shifts data into the 8-byte memory lane and generates the byte strobe.
- Issues one or two write beats on a valid/ready memory write port, waits for each write response, then reports completion to the MEM stage.

---
 rtl/ysyx_041514_lsu_store.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ysyx_041514_lsu_store.sv
// LSU store path: shifts right-justified store data into 8-byte memory lanes and issues one or two write beats.
// Define YSYX_041514_MISALIGN_SPLIT_EN to split stores that cross an 8-byte boundary; otherwise they complete with an error.
module ysyx_041514_lsu_store #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [XLEN-1:0]   st_addr_i,
  input  logic [XLEN-1:0]   st_data_i,
  input  logic [3:0]        st_size_i,
  output logic              st_done_o,
  output logic              st_err_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_wstrb_o,
  input  logic              mem_resp_valid_i,
  input  logic              mem_resp_err_i
);
  localparam int SW   = XLEN / 8;
  localparam int OFFW = $clog2(SW);
  localparam logic [2*SW-1:0] STRB_ONE = 1;

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_e;

  state_e            state_q;
  logic              st_ready_q, st_done_q, st_err_q, mem_valid_q;
  logic [XLEN-1:0]   mem_addr_q, mem_wdata_q, hi_addr_q, hi_data_q;
  logic [SW-1:0]     mem_wstrb_q, hi_strb_q;

  logic [3:0]        nbytes;
  logic [OFFW-1:0]   off;
  logic [2*XLEN-1:0] data_sh;
  logic [2*SW-1:0]   strb_sh;
  logic [XLEN-1:0]   base_addr;

  // nbytes of zero marks a size that is not one-hot
  always_comb begin
    nbytes = 4'd0;
    case (st_size_i)
      4'b0001: nbytes = 4'd1;
      4'b0010: nbytes = 4'd2;
      4'b0100: nbytes = 4'd4;
      4'b1000: nbytes = 4'd8;
      default: nbytes = 4'd0;
    endcase
  end

  assign off       = st_addr_i[OFFW-1:0];
  assign data_sh   = {{XLEN{1'b0}}, st_data_i} << {off, 3'b000};
  assign strb_sh   = ((STRB_ONE << nbytes) - STRB_ONE) << off;
  assign base_addr = {st_addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};

  // Memory port: a beat transfers on a cycle with mem_valid_o & mem_ready_i; once raised, valid and its
  // payload hold until that handshake. mem_resp_valid_i only counts in RSP0/RSP1, i.e. after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      st_ready_q  <= 1'b1;
      st_done_q   <= 1'b0;
      st_err_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      hi_addr_q   <= '0;
      hi_data_q   <= '0;
      hi_strb_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (st_valid_i && st_ready_q) begin
            st_ready_q <= 1'b0;
            hi_addr_q  <= base_addr + XLEN'(SW);
            hi_data_q  <= data_sh[2*XLEN-1:XLEN];
            hi_strb_q  <= strb_sh[2*SW-1:SW];
            if (nbytes == 4'd0) begin
              state_q   <= DONE;
              st_done_q <= 1'b1;
              st_err_q  <= 1'b1;
            end
`ifndef YSYX_041514_MISALIGN_SPLIT_EN
            else if (|strb_sh[2*SW-1:SW]) begin
              state_q   <= DONE;
              st_done_q <= 1'b1;
              st_err_q  <= 1'b1;
            end
`endif
            else begin
              state_q     <= REQ0;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= base_addr;
              mem_wdata_q <= data_sh[XLEN-1:0];
              mem_wstrb_q <= strb_sh[SW-1:0];
            end
          end
        end
        REQ0: begin
          if (mem_ready_i) begin
            mem_valid_q <= 1'b0;
            state_q     <= RSP0;
          end
        end
        RSP0: begin
          if (mem_resp_valid_i) begin
            if (mem_resp_err_i || hi_strb_q == '0) begin
              state_q   <= DONE;
              st_done_q <= 1'b1;
              st_err_q  <= mem_resp_err_i;
            end else begin
              state_q     <= REQ1;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= hi_addr_q;
              mem_wdata_q <= hi_data_q;
              mem_wstrb_q <= hi_strb_q;
            end
          end
        end
        REQ1: begin
          if (mem_ready_i) begin
            mem_valid_q <= 1'b0;
            state_q     <= RSP1;
          end
        end
        RSP1: begin
          if (mem_resp_valid_i) begin
            state_q   <= DONE;
            st_done_q <= 1'b1;
            st_err_q  <= st_err_q | mem_resp_err_i;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          st_done_q  <= 1'b0;
          st_err_q   <= 1'b0;
          st_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          st_ready_q  <= 1'b1;
          st_done_q   <= 1'b0;
          st_err_q    <= 1'b0;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign st_ready_o  = st_ready_q;
  assign st_done_o   = st_done_q;
  assign st_err_o    = st_err_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
endmodule
